// File: rtl/seq_arith_pkg.sv
// Shared types and helpers for the iterative multiplier family.
//   state_t  : controller states (IDLE, RUN, FIN)
//   steps_of : number of RUN cycles for an N-bit operand retiring K bits/cycle
//   width_ok : legality of an (N, K) pair
//   mag_of   : magnitude of a w-bit operand, two's complement or unsigned
package seq_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int unsigned steps_of(input int unsigned n, input int unsigned k);
    return n / k;
  endfunction

  function automatic bit width_ok(input int unsigned n, input int unsigned k);
    return (n >= 2) && (n <= 64) && (k >= 1) && (k <= n) && ((n % k) == 0);
  endfunction

  // Result is confined to w bits, so the signed minimum maps onto
  // 2^(w-1) without needing an extra bit.
  function automatic logic [63:0] mag_of(input logic [63:0] v, input int unsigned w,
                                         input logic is_signed);
    logic [63:0] mask;
    logic [63:0] vm;
    logic [63:0] top;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    vm   = v & mask;
    top  = vm >> (w - 1);
    if (is_signed && top[0]) begin
      return (~vm + 64'd1) & mask;
    end
    return vm;
  endfunction

endpackage

// File: rtl/seq_pp_step.sv
// One accumulation step of the shift-add multiplier.
//   acc       : running 2N-bit partial sum
//   a_shifted : multiplicand already aligned to the current bit group
//   b_low     : the K multiplier bits retired this cycle
//   acc_next  : acc + sum over i of (b_low[i] ? a_shifted << i : 0)
module seq_pp_step #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 1
) (
  input  logic [2*N-1:0] acc,
  input  logic [2*N-1:0] a_shifted,
  input  logic [K-1:0]   b_low,
  output logic [2*N-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    for (int unsigned i = 0; i < K; i++) begin
      if (b_low[i]) begin
        acc_next = acc_next + (a_shifted << i);
      end
    end
  end

endmodule

// File: rtl/seq_square_mult.sv
// Iterative squarer / multiplier retiring K multiplier bits per clock.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : request, accepted only in IDLE
//   sq_mode    : 1 = a_in*a_in (b_in ignored), 0 = a_in*b_in
//   is_signed  : operands are two's complement when 1
//   a_in, b_in : N-bit operands, sampled on the accept edge only
//   busy       : operation in flight (RUN or FIN)
//   done       : one-cycle pulse when out carries a fresh result
//   out        : 2N-bit product, held until the next completion
module seq_square_mult
  import seq_arith_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned K = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sq_mode,
  input  logic           is_signed,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] out
);

  localparam int unsigned STEPS = steps_of(N, K);
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!width_ok(N, K)) begin : g_bad_width
    $error("seq_square_mult: N must be in 2..64 and a multiple of K");
  end

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] a_sh;
  logic [N-1:0]   mag_b;
  logic           neg;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_nx;
  logic [2*N-1:0] out_q;
  logic           done_q;

  logic [N-1:0]   b_eff;
  logic [N-1:0]   mag_a_in;
  logic [N-1:0]   mag_b_in;
  logic           neg_in;

  // Square mode reuses A as the multiplier, so the sign can never differ.
  assign b_eff    = sq_mode ? a_in : b_in;
  assign mag_a_in = N'(mag_of(64'(a_in), N, is_signed));
  assign mag_b_in = N'(mag_of(64'(b_eff), N, is_signed));
  assign neg_in   = is_signed & ~sq_mode & (a_in[N-1] ^ b_in[N-1]);

  seq_pp_step #(
    .N (N),
    .K (K)
  ) u_step (
    .acc       (acc),
    .a_shifted (a_sh),
    .b_low     (mag_b[K-1:0]),
    .acc_next  (acc_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == '0) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      a_sh   <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= (2*N)'(mag_a_in);
            mag_b <= mag_b_in;
            neg   <= neg_in;
            acc   <= '0;
            cnt   <= CW'(STEPS - 1);
          end
        end
        RUN: begin
          acc   <= acc_nx;
          a_sh  <= a_sh << K;
          mag_b <= mag_b >> K;
          cnt   <= cnt - CW'(1);
        end
        FIN: begin
          out_q <= neg ? (~acc + (2*N)'(1)) : acc;
        end
        default: ;
      endcase
    end
  end

  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_seq_square_mult.sv
module tb_seq_square_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // N=8, K=1 instance (directed tests)
  logic        start = 1'b0, sq_mode = 1'b0, is_signed = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        busy, done;
  logic [15:0] out;

  // N=8, K=2 instance (sweep)
  logic        start2 = 1'b0, sq2 = 1'b0, sg2 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        busy2, done2;
  logic [15:0] out2;

  // N=16, K=4 instance (sweep)
  logic        start3 = 1'b0, sq3 = 1'b0, sg3 = 1'b0;
  logic [15:0] a3 = '0, b3 = '0;
  logic        busy3, done3;
  logic [31:0] out3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] last_out = '0;

  always #5 clk = ~clk;

  seq_square_mult #(.N(8), .K(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sq_mode(sq_mode), .is_signed(is_signed),
    .a_in(a), .b_in(b), .busy(busy), .done(done), .out(out));

  seq_square_mult #(.N(8), .K(2)) u_k2 (
    .clk(clk), .rst(rst), .start(start2), .sq_mode(sq2), .is_signed(sg2),
    .a_in(a2), .b_in(b2), .busy(busy2), .done(done2), .out(out2));

  seq_square_mult #(.N(16), .K(4)) u_n16 (
    .clk(clk), .rst(rst), .start(start3), .sq_mode(sq3), .is_signed(sg3),
    .a_in(a3), .b_in(b3), .busy(busy3), .done(done3), .out(out3));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] av, input logic [7:0] bv,
                                       input logic sq, input logic sg);
    longint x, y;
    logic [7:0] bb;
    bb = sq ? av : bv;
    x  = sg ? longint'($signed(av)) : longint'({56'd0, av});
    y  = sg ? longint'($signed(bb)) : longint'({56'd0, bb});
    return 16'(x * y);
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] av, input logic [15:0] bv,
                                        input logic sq, input logic sg);
    longint x, y;
    logic [15:0] bb;
    bb = sq ? av : bv;
    x  = sg ? longint'($signed(av)) : longint'({48'd0, av});
    y  = sg ? longint'($signed(bb)) : longint'({48'd0, bb});
    return 32'(x * y);
  endfunction

  // Starts one operation on the K=1 instance and returns at the negedge of
  // the done cycle, so the caller may issue the next start in that cycle.
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic sq, input logic sg, input logic [15:0] exp,
                       input bit noisy);
    int unsigned e;
    int unsigned busy_cnt;
    bit seen;
    a = av; b = bv; sq_mode = sq; is_signed = sg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = 0; busy_cnt = 0; seen = 1'b0;
    while (e < 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      check({tag, "/hold"}, 64'(out), 64'(last_out));
      if (noisy) begin
        start = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
        sq_mode = 1'($urandom); is_signed = 1'($urandom);
      end
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    check({tag, "/done_seen"}, 64'(seen), 64'd1);
    check({tag, "/latency"}, 64'(e), 64'd9);
    check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'd9);
    check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "/out"}, 64'(out), 64'(exp));
    last_out = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e;
    int lat2, lat3;
    logic [15:0] got2;
    logic [31:0] got3;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/out", 64'(out), 64'd0);
    check("rst/k2_out", 64'(out2), 64'd0);
    check("rst/n16_out", 64'(out3), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned square of the largest operand, then single-cycle done
    do_op("usq_255", 8'd255, 8'd0, 1'b1, 1'b0, 16'hFE01, 1'b0);
    @(negedge clk);
    check("usq_255/done_pulse", 64'(done), 64'd0);
    check("usq_255/out_held", 64'(out), 64'hFE01);

    // Signed cases, issued back to back
    do_op("ssq_m128", 8'h80, 8'h00, 1'b1, 1'b1, 16'h4000, 1'b0);
    do_op("smul_m3x5", 8'hFD, 8'h05, 1'b0, 1'b1, 16'hFFF1, 1'b0);
    do_op("smul_m7xm9", 8'hF9, 8'hF7, 1'b0, 1'b1, 16'h003F, 1'b0);
    do_op("umul_253x5", 8'hFD, 8'h05, 1'b0, 1'b0, 16'h04F1, 1'b0);
    do_op("ssq_m7_bign", 8'hF9, 8'h55, 1'b1, 1'b1, 16'h0031, 1'b0);

    // Unsigned multiply, then a start in the done cycle with a zero operand
    do_op("umul_200x3", 8'd200, 8'd3, 1'b0, 1'b0, 16'h0258, 1'b0);
    do_op("zero_x77", 8'd0, 8'd77, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);

    // Start and operands churned while busy
    do_op("noisy_13x11", 8'd13, 8'd11, 1'b0, 1'b0, 16'h008F, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("noisy/no_restart", 64'(busy), 64'd0);
    end

    // Asynchronous reset three cycles into RUN
    a = 8'd100; b = 8'd100; sq_mode = 1'b0; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst/busy", 64'(busy), 64'd0);
    check("arst/done", 64'(done), 64'd0);
    check("arst/out", 64'(out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_out = '0;
    e = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) e++;
    end
    check("arst/no_done", 64'(e), 64'd0);
    do_op("after_rst_12x12", 8'd12, 8'd12, 1'b0, 1'b0, 16'h0090, 1'b0);
    @(negedge clk);

    // Sweep on the K=2 and N=16/K=4 builds, cycling through all four modes
    for (int i = 0; i < 1000; i++) begin
      a2 = 8'($urandom);  b2 = 8'($urandom);
      a3 = 16'($urandom); b3 = 16'($urandom);
      sq2 = 1'(i % 2); sg2 = 1'((i / 2) % 2);
      sq3 = 1'((i / 2) % 2); sg3 = 1'(i % 2);
      if (i == 0) begin a2 = 8'h80; a3 = 16'h8000; end
      start2 = 1'b1; start3 = 1'b1;
      @(negedge clk);
      start2 = 1'b0; start3 = 1'b0;
      e = 0; lat2 = -1; lat3 = -1; got2 = '0; got3 = '0;
      while (e < 30 && (lat2 < 0 || lat3 < 0)) begin
        if (done2 && lat2 < 0) begin lat2 = int'(e); got2 = out2; end
        if (done3 && lat3 < 0) begin lat3 = int'(e); got3 = out3; end
        if (lat2 < 0 || lat3 < 0) begin
          @(negedge clk);
          e++;
        end
      end
      check("k2/latency", 64'(lat2), 64'd5);
      check("k2/out", 64'(got2), 64'(ref8(a2, b2, sq2, sg2)));
      check("n16/latency", 64'(lat3), 64'd5);
      check("n16/out", 64'(got3), 64'(ref16(a3, b3, sq3, sg3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
